alert_system: RTL and testbench
===============================

// Module: alert_system
// PURPOSE
//   Elevator safety alert block. Watches the door-open and overweight status lines.
//   Raises DOOR_ALERT when the door stays open too long, and WEIGHT_ALERT when an
//   overweight condition persists past a debounce window.
//   Sits between the cabin sensor interface and the elevator controller/annunciator.
//   Outputs are registered, level-type alerts.
// PARAMETERS
//   DOOR_TIMEOUT     10  consecutive clk cycles with DOOR_STATUS=1 before DOOR_ALERT; legal >=1
//   WEIGHT_DEBOUNCE  1   consecutive clk cycles with WEIGHT_STATUS=1 before WEIGHT_ALERT; legal >=1
//   CNT_W            localparam = $clog2(max(DOOR_TIMEOUT,WEIGHT_DEBOUNCE)+1); counter width
// PORTS
//   clk            in   1  system clock; all state updates on rising edge
//   rst            in   1  asynchronous, active-high reset
//   DOOR_STATUS    in   1  1 = door open, 0 = closed; synchronous to clk
//   WEIGHT_STATUS  in   1  1 = load above limit, 0 = within limit; synchronous to clk
//   DOOR_ALERT     out  1  registered; 1 = door open for >= DOOR_TIMEOUT cycles
//   WEIGHT_ALERT   out  1  registered; 1 = overweight for >= WEIGHT_DEBOUNCE cycles
// BEHAVIOUR
// - Interface: one clock (clk); reset rst is asynchronous and active-high.
// - Reset: while rst=1, both counters=0, DOOR_ALERT=0, WEIGHT_ALERT=0, regardless of clk.
//   Reset release takes effect from the first rising edge after deassertion.
// - Inputs are already synchronous to clk. The block has no synchronizer or glitch filter
//   beyond the persistence counters.
// - Each channel is an independent persistence timer with identical rules, using
//   (TH = DOOR_TIMEOUT or WEIGHT_DEBOUNCE, S = status input, A = alert output):
//     edge with S=0: cnt<=0, A<=0. Alert clears on the first edge sampling S=0.
//     edge with S=1, A=0: if cnt==TH-1 then A<=1, else cnt<=cnt+1.
//     edge with S=1, A=1: hold. cnt saturates and never wraps, for any open duration.
// - Latency: A rises on the TH-th consecutive rising edge that samples S=1.
//   For TH=1, that is the first such edge.
// - A single S=0 sample anywhere in the run restarts the count from 0. There is no hysteresis.
// - Channels are fully independent. Simultaneous door and weight events raise both alerts,
//   each per its own threshold. There is no priority and no masking.
// - Reset mid-count or mid-alert: immediate clear. The count restarts after release.
// - No X propagation: all state has a defined reset value.
// - No combinational input-to-output path.
// STRUCTURE
// - Shared package alert_pkg:
//     DEFAULT_DOOR_TIMEOUT = 10
//     DEFAULT_WEIGHT_DEBOUNCE = 1
//     function clog2_min1 for counter sizing
// - Sub-module alert_persist_timer (params TH, CNT_W; ports clk, rst, status, alert).
//   Instantiated twice: door channel and weight channel.
//   Top level is wiring plus parameter legality checks (elaboration error if TH<1).
// TESTING (clk period 10 ns, defaults unless noted)
// 1. rst=1 for 3 cycles with both inputs 1
//    -> both alerts 0 throughout. After release, the counts start from 0.
// 2. DOOR_STATUS=1 for 20 cycles, then 0
//    -> DOOR_ALERT=0 for edges 1-9, =1 from edge 10 through 20, =0 on first edge sampling 0.
// 3. WEIGHT_STATUS=1 for 10 cycles, then 0
//    -> WEIGHT_ALERT=1 from edge 1 through 10, =0 on the next edge. DOOR_ALERT stays 0.
// 4. DOOR_STATUS=1 and WEIGHT_STATUS=1 together for 20 cycles
//    -> WEIGHT_ALERT=1 at edge 1, DOOR_ALERT=1 at edge 10. Both clear together after release.
// 5. DOOR_STATUS=1 for 9 cycles, 0 for 1, 1 for 9 -> DOOR_ALERT never asserts (restart).
//    Then hold open for 300 cycles -> alert stays 1 (no counter wrap).
// 6. rst pulsed asynchronously between edges while DOOR_ALERT=1
//    -> alert drops immediately. With DOOR_STATUS still 1, it reasserts 10 edges after release.

Source files
------------

// File: rtl/alert_pkg.sv
// Shared constants and sizing helper for the elevator alert block.
package alert_pkg;

  localparam int DEFAULT_DOOR_TIMEOUT    = 10;
  localparam int DEFAULT_WEIGHT_DEBOUNCE = 1;

  // Bit width needed to hold values 0..v-1, never less than one bit.
  function automatic int clog2_min1(input int v);
    int w;
    w = $clog2(v);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/alert_persist_timer.sv
// Persistence timer: raises a level alert after TH consecutive cycles of status=1.
module alert_persist_timer
  import alert_pkg::*;
#(
  parameter int TH    = DEFAULT_DOOR_TIMEOUT,
  parameter int CNT_W = clog2_min1(TH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic status,
  output logic alert
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             alert_q, alert_d;

  always_comb begin
    cnt_d   = cnt_q;
    alert_d = alert_q;
    if (!status) begin
      cnt_d   = '0;
      alert_d = 1'b0;
    end else if (!alert_q) begin
      // Count stops once the alert is up, so it cannot wrap during a long hold.
      if (cnt_q == CNT_W'(TH - 1)) begin
        alert_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      alert_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      alert_q <= alert_d;
    end
  end

  assign alert = alert_q;

endmodule

// File: rtl/alert_system.sv
// Elevator safety alerts: door-open timeout and overweight debounce, independent channels.
module alert_system
  import alert_pkg::*;
#(
  parameter int DOOR_TIMEOUT    = DEFAULT_DOOR_TIMEOUT,
  parameter int WEIGHT_DEBOUNCE = DEFAULT_WEIGHT_DEBOUNCE
) (
  input  logic clk,
  input  logic rst,
  input  logic DOOR_STATUS,
  input  logic WEIGHT_STATUS,
  output logic DOOR_ALERT,
  output logic WEIGHT_ALERT
);

  localparam int MaxTh = (DOOR_TIMEOUT > WEIGHT_DEBOUNCE) ? DOOR_TIMEOUT : WEIGHT_DEBOUNCE;
  localparam int CNT_W = clog2_min1(MaxTh + 1);

  if (DOOR_TIMEOUT < 1) begin : g_bad_door_timeout
    $error("alert_system: DOOR_TIMEOUT must be >= 1");
  end
  if (WEIGHT_DEBOUNCE < 1) begin : g_bad_weight_debounce
    $error("alert_system: WEIGHT_DEBOUNCE must be >= 1");
  end

  alert_persist_timer #(
    .TH    (DOOR_TIMEOUT),
    .CNT_W (CNT_W)
  ) u_door_timer (
    .clk    (clk),
    .rst    (rst),
    .status (DOOR_STATUS),
    .alert  (DOOR_ALERT)
  );

  alert_persist_timer #(
    .TH    (WEIGHT_DEBOUNCE),
    .CNT_W (CNT_W)
  ) u_weight_timer (
    .clk    (clk),
    .rst    (rst),
    .status (WEIGHT_STATUS),
    .alert  (WEIGHT_ALERT)
  );

endmodule

// File: tb/tb_alert_system.sv
// Directed self-checking bench for alert_system at default thresholds (10 / 1).
module tb_alert_system;

  logic clk;
  logic rst;
  logic door_status;
  logic weight_status;
  logic door_alert;
  logic weight_alert;

  int checks;
  int errors;

  alert_system u_dut (
    .clk           (clk),
    .rst           (rst),
    .DOOR_STATUS   (door_status),
    .WEIGHT_STATUS (weight_status),
    .DOOR_ALERT    (door_alert),
    .WEIGHT_ALERT  (weight_alert)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    door_status   = 1'b1;
    weight_status = 1'b1;
    #2;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (door_alert !== 1'b0 || weight_alert !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: door=%b weight=%b required door=0 weight=0",
                 k, door_alert, weight_alert);
      end
    end
    rst = 1'b0;
    // Inputs still high: count must start from zero after release.
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (door_alert !== (k >= 10) || weight_alert !== 1'b1) begin
        errors++;
        $display("FAIL reset_release edge%0d: door=%b weight=%b required door=%b weight=1",
                 k, door_alert, weight_alert, (k >= 10));
      end
    end
    door_status   = 1'b0;
    weight_status = 1'b0;
    tick();
    checks++;
    if (door_alert !== 1'b0 || weight_alert !== 1'b0) begin
      errors++;
      $display("FAIL reset_clear: door=%b weight=%b required door=0 weight=0",
               door_alert, weight_alert);
    end
  endtask

  task automatic test_door_timeout();
    door_status = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++;
      if (door_alert !== (k >= 10) || weight_alert !== 1'b0) begin
        errors++;
        $display("FAIL door_timeout edge%0d: door=%b weight=%b required door=%b weight=0",
                 k, door_alert, weight_alert, (k >= 10));
      end
    end
    door_status = 1'b0;
    tick();
    checks++;
    if (door_alert !== 1'b0) begin
      errors++;
      $display("FAIL door_clear: door=%b required 0", door_alert);
    end
  endtask

  task automatic test_weight_debounce();
    weight_status = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (weight_alert !== 1'b1 || door_alert !== 1'b0) begin
        errors++;
        $display("FAIL weight_debounce edge%0d: weight=%b door=%b required weight=1 door=0",
                 k, weight_alert, door_alert);
      end
    end
    weight_status = 1'b0;
    tick();
    checks++;
    if (weight_alert !== 1'b0) begin
      errors++;
      $display("FAIL weight_clear: weight=%b required 0", weight_alert);
    end
  endtask

  task automatic test_both();
    door_status   = 1'b1;
    weight_status = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++;
      if (door_alert !== (k >= 10) || weight_alert !== 1'b1) begin
        errors++;
        $display("FAIL both edge%0d: door=%b weight=%b required door=%b weight=1",
                 k, door_alert, weight_alert, (k >= 10));
      end
    end
    door_status   = 1'b0;
    weight_status = 1'b0;
    tick();
    checks++;
    if (door_alert !== 1'b0 || weight_alert !== 1'b0) begin
      errors++;
      $display("FAIL both_clear: door=%b weight=%b required door=0 weight=0",
               door_alert, weight_alert);
    end
  endtask

  task automatic test_restart_and_hold();
    door_status = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++;
      if (door_alert !== 1'b0) begin
        errors++;
        $display("FAIL restart_first edge%0d: door=%b required 0", k, door_alert);
      end
    end
    door_status = 1'b0;
    tick();
    checks++;
    if (door_alert !== 1'b0) begin
      errors++;
      $display("FAIL restart_gap: door=%b required 0", door_alert);
    end
    door_status = 1'b1;
    for (int k = 1; k <= 309; k++) begin
      tick();
      checks++;
      if (door_alert !== (k >= 10)) begin
        errors++;
        $display("FAIL restart_hold edge%0d: door=%b required %b", k, door_alert, (k >= 10));
      end
    end
  endtask

  // Entered with DOOR_STATUS=1 and DOOR_ALERT=1.
  task automatic test_async_reset();
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (door_alert !== 1'b0 || weight_alert !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: door=%b weight=%b required door=0 weight=0",
               door_alert, weight_alert);
    end
    #1;
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (door_alert !== (k >= 10)) begin
        errors++;
        $display("FAIL async_rearm edge%0d: door=%b required %b", k, door_alert, (k >= 10));
      end
    end
    door_status = 1'b0;
    tick();
    checks++;
    if (door_alert !== 1'b0) begin
      errors++;
      $display("FAIL async_final_clear: door=%b required 0", door_alert);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    door_status   = 1'b0;
    weight_status = 1'b0;
    test_reset();
    test_door_timeout();
    test_weight_debounce();
    test_both();
    test_restart_and_hold();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
